// File: rtl/gate_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_check_pkg
// Purpose  : Shared types, widths and helpers for the gate truth-table
//            checker (FSM state encoding, counter/index/error widths and a
//            saturating error-count increment).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gate_check_pkg;

    localparam int IDX_W = 2;   // vector index width (4 vectors)
    localparam int CNT_W = 4;   // settle counter width (SETTLE up to 15)
    localparam int ERR_W = 3;   // error count width (0..4)

    localparam logic [IDX_W-1:0] c_LAST_IDX = 2'd3;
    localparam logic [ERR_W-1:0] c_ERR_MAX  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Error count never wraps; it sticks at the maximum number of vectors.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v >= c_ERR_MAX) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_check_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : gate_check_settle_cnt
// Purpose  : Down-counter that times the settle interval between driving a
//            test vector and sampling the gate response.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous active-high reset
//            load     - load counter with load_val
//            load_val - settle interval in cycles (1..15)
//            expired  - high during the last cycle of the interval
// Revision : 1.0 - initial release
// ============================================================================
module gate_check_settle_cnt
    import gate_check_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;

    // Counts down freely once loaded and parks at zero, so no separate
    // enable is needed: the FSM only looks at expired while it waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A value of one means this is the final waiting cycle; the FSM moves
    // on at the same edge that takes the count to zero.
    assign expired = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_truth_checker
// Purpose  : Walks all four {a,b} input vectors into a two-input gate under
//            test, waits SETTLE cycles per vector, compares the returned y
//            against the TRUTH table and reports pass/err_count/fail_vec.
// Params   : TRUTH  - expected y for vector i={a,b} in bit i (default NOR)
//            SETTLE - wait cycles between drive and sample, 1..15
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            start     - request a run, honoured only when idle
//            a_out     - registered stimulus a
//            b_out     - registered stimulus b
//            y_in      - gate response
//            busy      - high whenever a run is in progress
//            done      - one-cycle end-of-run pulse
//            pass      - run result, held until the next accepted start
//            err_count - number of mismatching vectors (0..4)
//            fail_vec  - bit i set when vector i mismatched
// Revision : 1.0 - initial release
// ============================================================================
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter logic [3:0]  TRUTH  = 4'b0001,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic [3:0]         r_fail;

    logic               w_load;
    logic               w_expired;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;

    assign w_load     = (r_state == DRIVE);
    assign w_mismatch = (y_in != TRUTH[r_idx]);
    assign w_err_next = w_mismatch ? err_sat_inc(r_err) : r_err;

    gate_check_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (c_SETTLE_LOAD),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_err   <= '0;
                        r_fail  <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_a     <= r_idx[1];
                    r_b     <= r_idx[0];
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_expired) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch) begin
                        r_fail[r_idx] <= 1'b1;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        // Result is published on entry to DONE so that pass
                        // is already valid while the done pulse is high; it
                        // must include the final sample, hence w_err_next.
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_truth_checker
// Purpose  : Self-checking bench for gate_truth_checker. Two instances (default
//            SETTLE and SETTLE=5) each drive a behavioural gate described by
//            a 4-entry table; expected run results are queued at start and
//            checked by a monitor when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_truth_checker;

    localparam logic [3:0] c_TRUTH = 4'b0001;  // NOR
    localparam int         c_S0    = 2;
    localparam int         c_S1    = 5;

    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       p;
        int         start_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fail0, fail1;
    logic [3:0] gate0, gate1;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test: y is the table entry selected by {a,b}.
    assign y0 = gate0[{a0, b0}];
    assign y1 = gate1[{a1, b1}];

    gate_truth_checker #(.TRUTH(c_TRUTH), .SETTLE(c_S0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0),
        .y_in(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    gate_truth_checker #(.TRUTH(c_TRUTH), .SETTLE(c_S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
        .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: a vector mismatches when the gate's output for {a,b}=i
    // differs from the expected truth bit i.
    function automatic exp_t model(input logic [3:0] truth, input logic [3:0] g, input int sc);
        exp_t e;
        e.fv = 4'b0000;
        e.ec = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (truth[i] != g[i]) begin
                e.fv[i] = 1'b1;
                e.ec    = e.ec + 3'd1;
            end
        end
        e.p         = (e.ec == 3'd0);
        e.start_cyc = sc;
        return e;
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? q0.size() : q1.size();
    endfunction

    task automatic check_done(input int which, input logic [3:0] fv, input logic [2:0] ec,
                              input logic p, input logic bz);
        exp_t e;
        int   lat_exp;
        if (qsize(which) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done dut%0d at cycle %0d", which, cyc);
            return;
        end
        if (which == 0) begin
            e       = q0.pop_front();
            lat_exp = 4 * (c_S0 + 2);
        end else begin
            e       = q1.pop_front();
            lat_exp = 4 * (c_S1 + 2);
        end
        chk($sformatf("fail_vec_dut%0d", which), fv, e.fv);
        chk($sformatf("err_count_dut%0d", which), ec, e.ec);
        chk($sformatf("pass_dut%0d", which), p, e.p);
        chk($sformatf("busy_at_done_dut%0d", which), bz, 1'b1);
        chk($sformatf("done_latency_dut%0d", which), cyc - e.start_cyc, lat_exp);
    endtask

    // Monitor: compares whenever a done pulse is presented.
    always @(negedge clk) begin
        if (done0 === 1'b1) check_done(0, fail0, err0, pass0, busy0);
        if (done1 === 1'b1) check_done(1, fail1, err1, pass1, busy1);
    end

    task automatic wait_empty(input int which);
        int n = 0;
        while (qsize(which) != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (qsize(which) != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout dut%0d: no done within %0d cycles", which, n);
            if (which == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    // Start a run, queue its expectation, wait for it and check idle hold.
    task automatic run(input int which, input logic [3:0] g);
        exp_t e;
        if (which == 0) gate0 = g; else gate1 = g;
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        e = model(c_TRUTH, g, cyc);
        if (which == 0) begin
            q0.push_back(e);
            start0 = 1'b0;
            chk("busy_after_start_dut0", busy0, 1'b1);
        end else begin
            q1.push_back(e);
            start1 = 1'b0;
            chk("busy_after_start_dut1", busy1, 1'b1);
        end
        wait_empty(which);
        // Idle: busy/done low, result held, last vector (a=1,b=1) held.
        if (which == 0)
            chk("idle_hold_dut0", {busy0, done0, pass0, err0, fail0, a0, b0},
                {1'b0, 1'b0, e.p, e.ec, e.fv, 1'b1, 1'b1});
        else
            chk("idle_hold_dut1", {busy1, done1, pass1, err1, fail1, a1, b1},
                {1'b0, 1'b0, e.p, e.ec, e.fv, 1'b1, 1'b1});
    endtask

    initial begin
        exp_t e;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        gate0  = 4'b0001;
        gate1  = 4'b0001;
        repeat (3) @(negedge clk);
        chk("reset_outputs_dut0", {a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
        chk("reset_outputs_dut1", {a1, b1, busy1, done1, pass1, err1, fail1}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed gates: NOR, AND, stuck-at-0, stuck-at-1.
        run(0, 4'b0001);
        run(0, 4'b1000);
        run(0, 4'b0000);
        run(0, 4'b1111);

        // start pulses while busy must be ignored and not queued.
        gate0 = 4'b0001;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(model(c_TRUTH, gate0, cyc));
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_empty(0);
        repeat (40) @(negedge clk);
        chk("idle_after_busy_start", busy0, 1'b0);

        // Reset mid-run while idx=2.
        gate0 = 4'b0001;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        e = model(c_TRUTH, gate0, cyc);
        q0.push_back(e);
        start0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_vector", {a0, b0, busy0}, 3'b101);
        rst = 1'b1;
        #1;
        chk("midrun_reset_dut0", {a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_reset", {busy0, done0}, 2'b00);
        run(0, 4'b0001);

        // SETTLE=5: AND run then NOR run back to back.
        run(1, 4'b1000);
        run(1, 4'b0001);

        // Randomized gate tables on both instances.
        for (int k = 0; k < 6; k++) begin
            run(0, 4'($urandom));
            run(1, 4'($urandom));
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
